// File: rtl/cbus_arbiter.sv
// Cache-bus arbiter: shares one downstream cache-bus port among NUM_PORTS requesters.
// Grants are decided in an IDLE cycle and held for the whole burst until the last beat.
package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  cbus_req_t  ireqs  [NUM_PORTS],
    output cbus_resp_t iresps [NUM_PORTS],
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     index_q;
    logic [IDX_W-1:0]     last_grant_q;
    logic [NUM_PORTS-1:0] valid_vec;
    logic                 any_valid;
    logic [IDX_W-1:0]     winner;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_valid
        assign valid_vec[gi] = ireqs[gi].valid;
    end

    // Scan from base+NUM_PORTS down to base+1 so the lowest offset (first in
    // rotation order) is written last and wins. Fixed priority starts the scan at port 0.
    always_comb begin
        int               base;
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        any_valid = 1'b0;
        winner    = '0;
        base      = ROUND_ROBIN ? int'(last_grant_q) : NUM_PORTS - 1;
        cand      = 0;
        cand_idx  = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            cand = base + k;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            cand_idx = IDX_W'(cand);
            if (valid_vec[cand_idx]) begin
                any_valid = 1'b1;
                winner    = cand_idx;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            index_q      <= '0;
            last_grant_q <= IDX_W'(NUM_PORTS - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        index_q      <= winner;
                        last_grant_q <= winner;
                        state_q      <= BUSY;
                    end
                end
                BUSY: begin
                    if (oresp.ready && oresp.last) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs depend only on registered state plus the routed payload, so reset
    // zeroes them immediately and oresp never reaches oreq.
    assign oreq = (state_q == BUSY) ? ireqs[index_q] : '0;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_resp
        assign iresps[gi] = (state_q == BUSY && index_q == IDX_W'(gi)) ? oresp : '0;
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: 2-port round-robin, 2-port fixed priority and 3-port
// round-robin instances share one stimulus table and a scoreboard of expected grants.
module tb_cbus_arbiter;
    import cbus_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       aresetn;
    cbus_req_t  req_v [3];
    cbus_req_t  req2  [2];
    cbus_resp_t oresp_v;

    cbus_req_t  oq_rr, oq_fp, oq_3;
    cbus_resp_t rs_rr [2];
    cbus_resp_t rs_fp [2];
    cbus_resp_t rs_3  [3];

    assign req2[0] = req_v[0];
    assign req2[1] = req_v[1];

    cbus_arbiter #(.NUM_PORTS(2), .ROUND_ROBIN(1'b1)) u_rr (
        .aclk(clk), .aresetn(aresetn), .ireqs(req2), .iresps(rs_rr), .oreq(oq_rr), .oresp(oresp_v));
    cbus_arbiter #(.NUM_PORTS(2), .ROUND_ROBIN(1'b0)) u_fp (
        .aclk(clk), .aresetn(aresetn), .ireqs(req2), .iresps(rs_fp), .oreq(oq_fp), .oresp(oresp_v));
    cbus_arbiter #(.NUM_PORTS(3), .ROUND_ROBIN(1'b1)) u_3 (
        .aclk(clk), .aresetn(aresetn), .ireqs(req_v), .iresps(rs_3), .oreq(oq_3), .oresp(oresp_v));

    // Per-cycle inputs plus the port each instance must be forwarding (-1 = IDLE).
    typedef struct {
        logic       v0, v1, v2, rdy, lst;
        logic [7:0] d0;
        int         e_rr, e_fp, e_3;
    } row_t;

    typedef struct {
        int row;
        int e_rr, e_fp, e_3;
    } exp_t;

    localparam int NROWS = 37;
    row_t tbl [NROWS];
    exp_t sb [$];
    int   n_err;
    int   n_checks;

    function automatic row_t mk(input logic v0, v1, v2, rdy, lst, input logic [7:0] d0,
                                input int e_rr, e_fp, e_3);
        row_t r;
        r.v0 = v0; r.v1 = v1; r.v2 = v2; r.rdy = rdy; r.lst = lst; r.d0 = d0;
        r.e_rr = e_rr; r.e_fp = e_fp; r.e_3 = e_3;
        return r;
    endfunction

    task automatic drive(input row_t r);
        req_v[0] = '{valid: r.v0, is_write: 1'b1, addr: 32'h1000_0000, len: 8'd1, size: 3'd2,
                     strobe: 4'b0110, data: {24'h0, r.d0}};
        req_v[1] = '{valid: r.v1, is_write: 1'b0, addr: 32'h8000_0040, len: 8'd3, size: 3'd2,
                     strobe: 4'b0000, data: 32'hdead_0001};
        req_v[2] = '{valid: r.v2, is_write: 1'b0, addr: 32'h2000_0080, len: 8'd0, size: 3'd2,
                     strobe: 4'b0000, data: 32'hdead_0002};
        oresp_v  = '{ready: r.rdy, last: r.lst, data: 32'($urandom)};
    endtask

    task automatic chk(input string nm, input int row, input int ep, input int np,
                       input cbus_req_t oq, input cbus_resp_t r0, r1, r2);
        cbus_req_t  eoq;
        cbus_resp_t got;
        cbus_resp_t want;
        if (ep < 0) eoq = '0;
        else        eoq = req_v[ep];
        n_checks++;
        if (oq !== eoq) begin
            n_err++;
            $display("FAIL %s oreq row=%0d grant=%0d got=%h want=%h", nm, row, ep, oq, eoq);
        end
        for (int i = 0; i < np; i++) begin
            got  = (i == 0) ? r0 : ((i == 1) ? r1 : r2);
            want = (i == ep) ? oresp_v : '0;
            n_checks++;
            if (got !== want) begin
                n_err++;
                $display("FAIL %s iresps[%0d] row=%0d got=%h want=%h", nm, i, row, got, want);
            end
        end
    endtask

    task automatic chk_all_idle(input string nm, input int row);
        chk({nm, "_rr"}, row, -1, 2, oq_rr, rs_rr[0], rs_rr[1], '0);
        chk({nm, "_fp"}, row, -1, 2, oq_fp, rs_fp[0], rs_fp[1], '0);
        chk({nm, "_p3"}, row, -1, 3, oq_3, rs_3[0], rs_3[1], rs_3[2]);
    endtask

    // Start a burst on port 0, then pull reset mid-burst and expect outputs to drop at once.
    task automatic mid_burst_reset();
        @(posedge clk); #1;
        drive(mk(1, 0, 0, 0, 0, 8'h33, 0, 0, 0));
        @(posedge clk); #1;
        drive(mk(1, 0, 0, 1, 0, 8'h33, 0, 0, 0));
        n_checks++;
        if (oq_rr.valid !== 1'b1) begin
            n_err++;
            $display("FAIL midburst_busy oreq.valid got=%b want=1", oq_rr.valid);
        end
        #1 aresetn = 1'b0;
        #1 chk_all_idle("midburst_reset", -1);
        $display("mid-burst reset applied");
        drive(mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
        @(negedge clk);
        aresetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        n_err    = 0;
        n_checks = 0;

        // contention, round-robin 0,1,0,1 vs fixed 0,0,0,0
        tbl[0]  = mk(1, 1, 0, 1, 1, 8'h11, -1, -1, -1);
        tbl[1]  = mk(1, 1, 0, 1, 1, 8'h11,  0,  0,  0);
        tbl[2]  = mk(1, 1, 0, 1, 1, 8'h11, -1, -1, -1);
        tbl[3]  = mk(1, 1, 0, 1, 1, 8'h11,  1,  0,  1);
        tbl[4]  = mk(1, 1, 0, 1, 1, 8'h11, -1, -1, -1);
        tbl[5]  = mk(1, 1, 0, 1, 1, 8'h11,  0,  0,  0);
        tbl[6]  = mk(1, 1, 0, 1, 1, 8'h11, -1, -1, -1);
        tbl[7]  = mk(1, 1, 0, 1, 1, 8'h11,  1,  0,  1);
        tbl[8]  = mk(0, 0, 0, 0, 0, 8'h11, -1, -1, -1);
        // single read burst on port 1: one stall, then 4 ready beats
        tbl[9]  = mk(0, 1, 0, 0, 0, 8'h11, -1, -1, -1);
        tbl[10] = mk(0, 1, 0, 0, 0, 8'h11,  1,  1,  1);
        tbl[11] = mk(0, 1, 0, 1, 0, 8'h11,  1,  1,  1);
        tbl[12] = mk(0, 1, 0, 1, 0, 8'h11,  1,  1,  1);
        tbl[13] = mk(0, 1, 0, 1, 0, 8'h11,  1,  1,  1);
        tbl[14] = mk(0, 1, 0, 1, 1, 8'h11,  1,  1,  1);
        tbl[15] = mk(0, 0, 0, 0, 0, 8'h11, -1, -1, -1);
        // port 1 drops valid mid-burst while port 0 waits
        tbl[16] = mk(0, 1, 0, 0, 0, 8'h11, -1, -1, -1);
        tbl[17] = mk(1, 1, 0, 1, 0, 8'h11,  1,  1,  1);
        tbl[18] = mk(1, 0, 0, 1, 0, 8'h11,  1,  1,  1);
        tbl[19] = mk(1, 0, 0, 1, 0, 8'h11,  1,  1,  1);
        tbl[20] = mk(1, 0, 0, 1, 1, 8'h11,  1,  1,  1);
        tbl[21] = mk(1, 0, 0, 0, 0, 8'h11, -1, -1, -1);
        tbl[22] = mk(1, 0, 0, 1, 1, 8'h11,  0,  0,  0);
        tbl[23] = mk(0, 0, 0, 0, 0, 8'h11, -1, -1, -1);
        // write burst on port 0, data changes after the first ready beat
        tbl[24] = mk(1, 0, 0, 0, 0, 8'h11, -1, -1, -1);
        tbl[25] = mk(1, 0, 0, 1, 0, 8'h11,  0,  0,  0);
        tbl[26] = mk(1, 0, 0, 1, 1, 8'h22,  0,  0,  0);
        tbl[27] = mk(0, 0, 0, 0, 0, 8'h22, -1, -1, -1);
        // after a fresh reset: 3-port wrap-around 1,2,0,1
        tbl[28] = mk(0, 1, 1, 1, 1, 8'h44, -1, -1, -1);
        tbl[29] = mk(1, 1, 1, 1, 1, 8'h44,  1,  1,  1);
        tbl[30] = mk(1, 1, 1, 1, 1, 8'h44, -1, -1, -1);
        tbl[31] = mk(1, 1, 1, 1, 1, 8'h44,  0,  0,  2);
        tbl[32] = mk(1, 1, 1, 1, 1, 8'h44, -1, -1, -1);
        tbl[33] = mk(1, 1, 1, 1, 1, 8'h44,  1,  0,  0);
        tbl[34] = mk(1, 1, 1, 1, 1, 8'h44, -1, -1, -1);
        tbl[35] = mk(1, 1, 1, 1, 1, 8'h44,  0,  0,  1);
        tbl[36] = mk(0, 0, 0, 0, 0, 8'h44, -1, -1, -1);

        // reset held with every requester valid and downstream ready
        aresetn = 1'b0;
        drive(mk(1, 1, 1, 1, 1, 8'h55, 0, 0, 0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_all_idle("reset", -1);
            $display("reset cycle %0d checked", c);
        end
        drive(mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
        aresetn = 1'b1;

        for (int i = 0; i < NROWS; i++) begin
            if (i == 28) mid_burst_reset();
            @(posedge clk); #1;
            drive(tbl[i]);
            sb.push_back('{row: i, e_rr: tbl[i].e_rr, e_fp: tbl[i].e_fp, e_3: tbl[i].e_3});
            @(negedge clk);
            e = sb.pop_front();
            chk("rr2", e.row, e.e_rr, 2, oq_rr, rs_rr[0], rs_rr[1], '0);
            chk("fix2", e.row, e.e_fp, 2, oq_fp, rs_fp[0], rs_fp[1], '0);
            chk("rr3", e.row, e.e_3, 3, oq_3, rs_3[0], rs_3[1], rs_3[2]);
            $display("row %0d: grant rr2=%0d fix2=%0d rr3=%0d rdy=%b last=%b",
                     e.row, e.e_rr, e.e_fp, e.e_3, oresp_v.ready, oresp_v.last);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
